// File: rtl/fnd_scan_controller_if.sv
// Bus between the up-counter/board side and fnd_scan_controller.
// The controller's view is "slave"; the counter/board or a testbench uses "master".
interface fnd_scan_controller_if;
    // There is no valid/ready pair. i_counter_data is a level that the
    // converter samples on its own schedule, once every 16 cycles.
    // o_digitSelect and o_fndFont are registered levels that are always valid
    // after reset. dbg_state shows the converter FSM state for checkers.
    logic [13:0] i_counter_data;
    logic [3:0]  o_digitSelect;
    logic [7:0]  o_fndFont;
    logic [1:0]  dbg_state;

    modport master (output i_counter_data, input o_digitSelect, o_fndFont, dbg_state);
    modport slave  (input i_counter_data, output o_digitSelect, o_fndFont, dbg_state);
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD (serial double dabble) plus a 4-digit multiplexed FND scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module fnd_scan_controller #(
    parameter int SCAN_DIV  = 100000,
    parameter int MAX_VALUE = 9999
) (
    input logic                  i_clk,
    input logic                  i_reset,
    fnd_scan_controller_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [13:0]     MAX_V      = 14'(MAX_VALUE);

    logic [1:0]    state;
    logic [3:0]    shift_cnt;
    logic [13:0]   bin_reg;
    logic [15:0]   bcd_work;
    logic [15:0]   bcd_disp;
    logic [11:0]   bcd_adj_lo;
    logic [15:0]   bcd_next;
    logic [13:0]   clamped;
    logic [PW-1:0] presc;
    logic [1:0]    digit_idx;
    logic [3:0]    cur_nib;
    logic [3:0]    sel_next;
    logic [7:0]    font_next;
    logic [3:0]    sel_q;
    logic [7:0]    font_q;

    assign clamped = (bus.i_counter_data > MAX_V) ? MAX_V : bus.i_counter_data;

    // The upper nibble is never adjusted. With the input clamped to 9999, the
    // prefix converted so far never exceeds 4999, so that nibble stays below 5.
    always_comb begin
        bcd_adj_lo = bcd_work[11:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj_lo[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_work[14:12], bcd_adj_lo, bin_reg[13]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            shift_cnt <= 4'd0;
            bin_reg   <= 14'd0;
            bcd_work  <= 16'd0;
            bcd_disp  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bin_reg   <= clamped;
                    bcd_work  <= 16'd0;
                    shift_cnt <= 4'd0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_work  <= bcd_next;
                    bin_reg   <= {bin_reg[12:0], 1'b0};
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'd13) state <= ST_DONE;
                end
                ST_DONE: begin
                    // Single 16-bit copy, so the display never sees a half-converted value.
                    bcd_disp <= bcd_work;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc     <= '0;
            digit_idx <= 2'd0;
        end else if (presc == PRESC_LAST) begin
            presc     <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        sel_next = 4'b1110;
        case (digit_idx)
            2'd0: begin cur_nib = bcd_disp[3:0];   sel_next = 4'b1110; end
            2'd1: begin cur_nib = bcd_disp[7:4];   sel_next = 4'b1101; end
            2'd2: begin cur_nib = bcd_disp[11:8];  sel_next = 4'b1011; end
            default: begin cur_nib = bcd_disp[15:12]; sel_next = 4'b0111; end
        endcase
        case (cur_nib)
            4'd0: font_next = 8'hC0;
            4'd1: font_next = 8'hF9;
            4'd2: font_next = 8'hA4;
            4'd3: font_next = 8'hB0;
            4'd4: font_next = 8'h99;
            4'd5: font_next = 8'h92;
            4'd6: font_next = 8'h82;
            4'd7: font_next = 8'hF8;
            4'd8: font_next = 8'h80;
            4'd9: font_next = 8'h90;
            default: font_next = 8'hFF;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_idx == 2'd3 && bcd_disp[15:12] == 4'd0) ||
            (digit_idx == 2'd2 && bcd_disp[15:8]  == 8'd0) ||
            (digit_idx == 2'd1 && bcd_disp[15:4]  == 12'd0))
            font_next = 8'hFF;
`endif
    end

    // Select and font share one register stage, so they always change on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sel_q  <= 4'b1110;
            font_q <= 8'hC0;
        end else begin
            sel_q  <= sel_next;
            font_q <= font_next;
        end
    end

    assign bus.o_digitSelect = sel_q;
    assign bus.o_fndFont     = font_q;
    assign bus.dbg_state     = state;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller with SCAN_DIV = 4.
// Expected fonts come from a decimal digit model; works with or without LEADING_ZERO_BLANK_EN.
module tb_fnd_scan_controller;
  logic clk;
  logic rst;
  int checks;
  int failures;

  fnd_scan_controller_if bus();

  fnd_scan_controller #(.SCAN_DIV(4), .MAX_VALUE(9999)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge after the last reset edge, with reset released.
  task automatic do_reset(input logic [13:0] value);
    @(negedge clk);
    rst = 1'b1;
    bus.i_counter_data = value;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] exp_font(input int value, input logic [3:0] sel);
    int d;
    int p;
    int digit;
    logic [7:0] lut [10];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    case (sel)
      4'b1110: d = 0;
      4'b1101: d = 1;
      4'b1011: d = 2;
      4'b0111: d = 3;
      default: return 8'h00;
    endcase
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    digit = (value / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && value < p) return 8'hFF;
`endif
    return lut[digit];
  endfunction

  function automatic logic [3:0] sel_of(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // driver tasks / scenarios
  task automatic test_reset();
    do_reset(14'd0);
    checks++;
    if (bus.o_digitSelect !== 4'b1110) begin
      failures++;
      $display("FAIL reset_sel got=%b exp=1110", bus.o_digitSelect);
    end
    checks++;
    if (bus.o_fndFont !== 8'hC0) begin
      failures++;
      $display("FAIL reset_font got=%h exp=c0", bus.o_fndFont);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", bus.dbg_state);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_fndFont !== exp_font(0, bus.o_digitSelect)) begin
        failures++;
        $display("FAIL zero_font k=%0d sel=%b got=%h exp=%h", k, bus.o_digitSelect,
                 bus.o_fndFont, exp_font(0, bus.o_digitSelect));
      end
    end
  endtask

  task automatic test_scan();
    do_reset(14'd1234);
    repeat (16) @(negedge clk);
    checks++;
    if (bus.o_digitSelect !== 4'b0111 || bus.o_fndFont !== exp_font(0, 4'b0111)) begin
      failures++;
      $display("FAIL pre_update sel=%b font=%h exp sel=0111 font=%h", bus.o_digitSelect,
               bus.o_fndFont, exp_font(0, 4'b0111));
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_digitSelect !== sel_of((k / 4) % 4) ||
          bus.o_fndFont !== exp_font(1234, sel_of((k / 4) % 4))) begin
        failures++;
        $display("FAIL scan_1234 k=%0d sel=%b font=%h exp sel=%b font=%h", k, bus.o_digitSelect,
                 bus.o_fndFont, sel_of((k / 4) % 4), exp_font(1234, sel_of((k / 4) % 4)));
      end
    end
  endtask

  task automatic test_values(input string name, input int shown [3], input int drive [3]);
    for (int v = 0; v < 3; v++) begin
      bus.i_counter_data = 14'(drive[v]);
      repeat (40) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        checks++;
        if (bus.o_fndFont !== exp_font(shown[v], bus.o_digitSelect)) begin
          failures++;
          $display("FAIL %s in=%0d sel=%b got=%h exp=%h", name, drive[v], bus.o_digitSelect,
                   bus.o_fndFont, exp_font(shown[v], bus.o_digitSelect));
        end
      end
    end
  endtask

  task automatic test_clamp();
    int shown [3];
    int drive [3];
    shown = '{9999, 9999, 9999};
    drive = '{9999, 10000, 16383};
    test_values("clamp", shown, drive);
  endtask

  task automatic test_leading_zero();
    int vals [3];
    vals = '{5, 0, 1000};
    test_values("leading_zero", vals, vals);
  endtask

  task automatic test_mid_conversion();
    int budget;
    int exp_v;
    bus.i_counter_data = 14'd7;
    repeat (40) @(negedge clk);
    budget = 0;
    while (bus.dbg_state !== 2'd0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 20) begin
      failures++;
      $display("FAIL idle_wait timeout state=%0d exp=0", bus.dbg_state);
    end else begin
      @(posedge clk);
      @(posedge clk);
      #1 bus.i_counter_data = 14'd42;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        exp_v = (k <= 31) ? 7 : 42;
        checks++;
        if (bus.o_fndFont !== exp_font(exp_v, bus.o_digitSelect)) begin
          failures++;
          $display("FAIL mid_conv k=%0d sel=%b got=%h exp=%h", k, bus.o_digitSelect,
                   bus.o_fndFont, exp_font(exp_v, bus.o_digitSelect));
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset(14'd1234);
    repeat (9) @(negedge clk);
    checks++;
    if (bus.dbg_state !== 2'd1 || bus.o_digitSelect !== 4'b1011) begin
      failures++;
      $display("FAIL pre_abort state=%0d sel=%b exp state=1 sel=1011", bus.dbg_state,
               bus.o_digitSelect);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_digitSelect !== 4'b1110 || bus.o_fndFont !== 8'hC0 || bus.dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL abort sel=%b font=%h state=%0d exp sel=1110 font=c0 state=0",
               bus.o_digitSelect, bus.o_fndFont, bus.dbg_state);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.o_digitSelect !== 4'b1110) begin
      failures++;
      $display("FAIL restart_hold sel=%b exp=1110", bus.o_digitSelect);
    end
    @(negedge clk);
    checks++;
    if (bus.o_digitSelect !== 4'b1101 || bus.o_fndFont !== exp_font(0, 4'b1101)) begin
      failures++;
      $display("FAIL restart_step sel=%b font=%h exp sel=1101 font=%h", bus.o_digitSelect,
               bus.o_fndFont, exp_font(0, 4'b1101));
    end
  endtask

  // one-low select scoreboard, checked every cycle outside reset
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (!(bus.o_digitSelect inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
        failures++;
        $display("FAIL one_low sel=%b", bus.o_digitSelect);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_counter_data = 14'd0;
    test_reset();
    test_scan();
    test_clamp();
    test_mid_conversion();
    test_reset_mid_op();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
